div_mon: RTL and testbench



---
 rtl/div_mon_pkg.sv | 15 +
 rtl/div_mon_edge_det.sv | 23 ++
 rtl/div_mon.sv | 186 ++++++++++++++++++
 tb/tb_div_mon.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/div_mon_pkg.sv
// Shared types and helpers for the divided-clock monitor.
package div_mon_pkg;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } mon_state_t;

  // Period counter width: must hold TIMEOUT plus a saturation headroom value.
  function automatic int cnt_width(input int timeout);
    return $clog2(timeout + 2);
  endfunction

endpackage

// File: rtl/div_mon_edge_det.sv
// Registers a clk-synchronous level and flags its rising and falling edges.
module edge_det (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_q;

  // One-cycle delayed copy; clears to 0 so a high input right after reset reads as a rise.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_q <= 1'b0;
    else          r_q <= i_d;
  end

  assign o_q    = r_q;
  assign o_rise = i_d & ~r_q;
  assign o_fall = ~i_d & r_q;

endmodule

// File: rtl/div_mon.sv
// Divided-clock monitor: measures each div_in period in clk cycles, declares
// lock after LOCK_COUNT consecutive correct periods and raises sticky flags
// for wrong periods and stalls. Define DUTY_CHECK_EN to add the high-time
// (duty) check; without it err_duty is tied to 0.
module div_mon
  import div_mon_pkg::*;
#(
  parameter int DIV_VALUE  = 5,
  parameter int LOCK_COUNT = 4,
  parameter int TIMEOUT    = 2 * DIV_VALUE,
  parameter int HIGH_MIN   = DIV_VALUE / 2,
  parameter int HIGH_MAX   = (DIV_VALUE + 1) / 2,
  parameter int CNT_W      = cnt_width(TIMEOUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             div_in,
  input  logic             clr_err,
  output logic [CNT_W-1:0] period,
  output logic             period_vld,
  output logic             locked,
  output logic             err_period,
  output logic             err_timeout,
  output logic             err_duty
);

  localparam int GOOD_W = $clog2(LOCK_COUNT + 1);

  localparam logic [CNT_W-1:0]  DIV_C     = CNT_W'(DIV_VALUE);
  localparam logic [CNT_W-1:0]  TO_LAST   = CNT_W'(TIMEOUT - 1);
  localparam logic [GOOD_W-1:0] LOCK_LAST = GOOD_W'(LOCK_COUNT - 1);
  localparam logic [CNT_W:0]    HMIN_C    = (CNT_W + 1)'(HIGH_MIN);
  localparam logic [CNT_W:0]    HMAX_C    = (CNT_W + 1)'(HIGH_MAX);

  logic w_div_q, w_rise, w_fall;
  logic w_good_per, w_timeout, w_duty_bad;
  logic [CNT_W-1:0] w_m;

  mon_state_t        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [GOOD_W-1:0] r_good;
  logic [CNT_W-1:0]  r_period;
  logic              r_period_vld, r_locked, r_err_period, r_err_timeout;

  edge_det u_edge (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_d     (div_in),
    .o_q     (w_div_q),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  // Measured period ends on the rise cycle itself, hence the +1.
  assign w_m        = r_cnt + 1'b1;
  assign w_good_per = (w_m == DIV_C);
  // A rise in the timeout cycle takes priority over the stall.
  assign w_timeout  = (r_state != ACQ) && !w_rise && (r_cnt == TO_LAST);

  // Period counter: restarts on every rise, saturates while the divider is idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)              r_cnt <= '0;
    else if (w_rise)       r_cnt <= '0;
    else if (r_cnt != '1)  r_cnt <= r_cnt + 1'b1;
  end

  // Lock FSM with registered period/lock outputs and sticky error flags (set beats clear).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= ACQ;
      r_good        <= '0;
      r_period      <= '0;
      r_period_vld  <= 1'b0;
      r_locked      <= 1'b0;
      r_err_period  <= 1'b0;
      r_err_timeout <= 1'b0;
    end else begin
      r_period_vld <= 1'b0;

      if (w_rise && (r_state != ACQ) && !w_good_per) r_err_period <= 1'b1;
      else if (clr_err)                               r_err_period <= 1'b0;

      if (w_timeout)    r_err_timeout <= 1'b1;
      else if (clr_err) r_err_timeout <= 1'b0;

      case (r_state)
        ACQ: begin
          if (w_rise) begin
            r_state <= TRACK;
            r_good  <= '0;
          end
        end
        TRACK: begin
          if (w_rise) begin
            r_period     <= w_m;
            r_period_vld <= 1'b1;
            if (!w_good_per) begin
              r_good <= '0;
            end else if (r_good == LOCK_LAST) begin
              r_state  <= LOCKED;
              r_locked <= 1'b1;
              r_good   <= '0;
            end else begin
              r_good <= r_good + 1'b1;
            end
          end else if (w_timeout) begin
            r_state  <= ACQ;
            r_locked <= 1'b0;
            r_good   <= '0;
          end
        end
        LOCKED: begin
          if (w_rise) begin
            r_period     <= w_m;
            r_period_vld <= 1'b1;
            if (!w_good_per) begin
              r_state  <= TRACK;
              r_locked <= 1'b0;
              r_good   <= '0;
            end
          end else if (w_timeout) begin
            r_state  <= ACQ;
            r_locked <= 1'b0;
            r_good   <= '0;
          end else if (w_duty_bad) begin
            r_state  <= TRACK;
            r_locked <= 1'b0;
            r_good   <= '0;
          end
        end
        default: begin
          r_state  <= ACQ;
          r_locked <= 1'b0;
          r_good   <= '0;
        end
      endcase
    end
  end

`ifdef DUTY_CHECK_EN
  logic [CNT_W-1:0] r_hc;
  logic             r_skip_fall;
  logic             r_err_duty;
  logic [CNT_W:0]   w_h;

  // High-time counter: counts cycles with the delayed level high, restarts on a rise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                        r_hc <= '0;
    else if (w_rise)                 r_hc <= '0;
    else if (w_div_q && r_hc != '1)  r_hc <= r_hc + 1'b1;
  end

  // Arms while outside TRACK so the first fall after entering TRACK is not judged.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                  r_skip_fall <= 1'b0;
    else if (r_state != TRACK) r_skip_fall <= 1'b1;
    else if (w_fall)           r_skip_fall <= 1'b0;
  end

  assign w_h        = {1'b0, r_hc} + 1'b1;
  assign w_duty_bad = w_fall
                    && ((r_state == LOCKED) || ((r_state == TRACK) && !r_skip_fall))
                    && ((w_h < HMIN_C) || (w_h > HMAX_C));

  // Sticky duty flag; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            r_err_duty <= 1'b0;
    else if (w_duty_bad) r_err_duty <= 1'b1;
    else if (clr_err)    r_err_duty <= 1'b0;
  end

  assign err_duty = r_err_duty;
`else
  logic w_unused_duty;
  assign w_unused_duty = w_fall | w_div_q | (|HMIN_C) | (|HMAX_C);
  assign w_duty_bad    = 1'b0;
  assign err_duty      = 1'b0;
`endif

  assign period      = r_period;
  assign period_vld  = r_period_vld;
  assign locked      = r_locked;
  assign err_period  = r_err_period;
  assign err_timeout = r_err_timeout;

endmodule

// File: tb/tb_div_mon.sv
// Directed bench for div_mon (DIV_VALUE=5, LOCK_COUNT=4, TIMEOUT=10).
// Each table row is one div_in period starting at its rise: high cycles,
// low cycles, clr_err on the rise cycle, and the outputs expected after the
// rise edge (they must then hold, with period_vld low, for the rest of the row).
module tb_div_mon;

  localparam int CNT_W = 4;

`ifdef DUTY_CHECK_EN
  localparam logic ED_D = 1'b1;
  localparam logic LK_D = 1'b0;
`else
  localparam logic ED_D = 1'b0;
  localparam logic LK_D = 1'b1;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             div_in;
  logic             clr_err;
  logic [CNT_W-1:0] period;
  logic             period_vld, locked, err_period, err_timeout, err_duty;

  always #5 clk = ~clk;

  div_mon dut (
    .clk         (clk),
    .rst         (rst),
    .div_in      (div_in),
    .clr_err     (clr_err),
    .period      (period),
    .period_vld  (period_vld),
    .locked      (locked),
    .err_period  (err_period),
    .err_timeout (err_timeout),
    .err_duty    (err_duty)
  );

  typedef struct {
    int   h;
    int   l;
    logic clr;
    logic vld;
    int   per;
    logic lk;
    logic ep;
    logic et;
  } vec_t;

  vec_t vecs[32];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic set_row(input int i, input int h, input int l, input logic clr,
                         input logic vld, input int per, input logic lk,
                         input logic ep, input logic et);
    vecs[i].h = h;     vecs[i].l = l;   vecs[i].clr = clr;
    vecs[i].vld = vld; vecs[i].per = per; vecs[i].lk = lk;
    vecs[i].ep = ep;   vecs[i].et = et;
  endtask

  task automatic check(input string name, input logic vld, input int per,
                       input logic lk, input logic ep, input logic et, input logic ed);
    logic [CNT_W-1:0] per_w;
    per_w = per[CNT_W-1:0];
    n_vec++;
    if (period_vld !== vld || period !== per_w || locked !== lk ||
        err_period !== ep || err_timeout !== et || err_duty !== ed) begin
      n_fail++;
      $display("FAIL %s: got vld=%0b per=%0d lk=%0b ep=%0b et=%0b ed=%0b, want vld=%0b per=%0d lk=%0b ep=%0b et=%0b ed=%0b",
               name, period_vld, period, locked, err_period, err_timeout, err_duty,
               vld, per_w, lk, ep, et, ed);
    end
  endtask

  // Drive one cycle's inputs, then sample 1 time unit after the active edge.
  task automatic step(input logic d, input logic c);
    div_in  = d;
    clr_err = c;
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      step(1'b1, vecs[i].clr);
      check($sformatf("row%0d_rise", i), vecs[i].vld, vecs[i].per,
            vecs[i].lk, vecs[i].ep, vecs[i].et, 1'b0);
      for (int k = 1; k < vecs[i].h + vecs[i].l; k++) begin
        step(k < vecs[i].h, 1'b0);
        check($sformatf("row%0d_c%0d", i, k), 1'b0, vecs[i].per,
              vecs[i].lk, vecs[i].ep, vecs[i].et, 1'b0);
      end
    end
  endtask

  initial begin
    // A: acquire, lock, bad period, relock, clr_err vs. simultaneous error
    set_row( 0, 3, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    set_row( 1, 2, 3, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    set_row( 2, 3, 2, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    set_row( 3, 2, 3, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    set_row( 4, 3, 2, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
    set_row( 5, 2, 2, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
    set_row( 6, 3, 2, 1'b0, 1'b1, 4, 1'b0, 1'b1, 1'b0);
    set_row( 7, 2, 3, 1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0);
    set_row( 8, 3, 2, 1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0);
    set_row( 9, 2, 3, 1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0);
    set_row(10, 3, 2, 1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b0);
    set_row(11, 2, 2, 1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b0);
    set_row(12, 3, 2, 1'b1, 1'b1, 4, 1'b0, 1'b1, 1'b0);
    set_row(13, 2, 3, 1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    set_row(14, 3, 2, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    set_row(15, 2, 3, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    set_row(16, 3, 2, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
    // B: reacquire after stall, lock, then a rise exactly on the timeout cycle
    set_row(17, 3, 2, 1'b0, 1'b0, 5, 1'b0, 1'b0, 1'b0);
    set_row(18, 2, 3, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    set_row(19, 3, 2, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    set_row(20, 2, 3, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    set_row(21, 3, 7, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);
    set_row(22, 3, 2, 1'b0, 1'b1, 10, 1'b0, 1'b1, 1'b0);
    // C: relock from TRACK with err_period still sticky
    set_row(23, 2, 3, 1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0);
    set_row(24, 3, 2, 1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0);
    set_row(25, 2, 3, 1'b0, 1'b1, 5, 1'b0, 1'b1, 1'b0);
    set_row(26, 3, 2, 1'b0, 1'b1, 5, 1'b1, 1'b1, 1'b0);
    // D: lock again after a mid-lock reset
    set_row(27, 3, 2, 1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
    set_row(28, 2, 3, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    set_row(29, 3, 2, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    set_row(30, 2, 3, 1'b0, 1'b1, 5, 1'b0, 1'b0, 1'b0);
    set_row(31, 3, 2, 1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b0);

    rst     = 1'b0;
    div_in  = 1'b0;
    clr_err = 1'b0;

    // Held in reset with div_in toggling: everything stays 0.
    for (int i = 0; i < 6; i++) begin
      step(i[0], 1'b0);
      check("reset_hold", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    step(1'b0, 1'b0);
    check("release_idle", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_rows(0, 16);

    // Stall while locked: last rise was 5 cycles ago; timeout lands on cycle 10.
    for (int k = 5; k <= 9; k++) begin
      step(1'b0, 1'b0);
      check($sformatf("stall_wait%0d", k), 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
    check("stall_timeout", 1'b0, 5, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("clr_quiet", 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 15; k++) begin
      step(1'b0, 1'b0);
      check("acq_no_timeout", 1'b0, 5, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    run_rows(17, 26);

    // Asynchronous reset while locked: outputs drop before any clock edge.
    rst = 1'b0;
    #1;
    check("async_reset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(~i[0], 1'b0);
      check("reset_mid", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b1;
    step(1'b0, 1'b0);
    check("release_mid", 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    run_rows(27, 31);

    // 5-cycle period with a 4-cycle high time while locked.
    step(1'b1, 1'b0);
    check("duty_rise", 1'b1, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 1; k < 4; k++) begin
      step(1'b1, 1'b0);
      check("duty_high", 1'b0, 5, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    step(1'b0, 1'b0);
    check("duty_fall", 1'b0, 5, LK_D, 1'b0, 1'b0, ED_D);
    step(1'b1, 1'b0);
    check("duty_next", 1'b1, 5, LK_D, 1'b0, 1'b0, ED_D);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
